// File: rtl/cap_mem_resp_model.sv
// OBI data-memory responder: tagged RAM, LFSR-driven grant/response wait states, in-order response FIFO.
// Optional build macro CAP_MEM_ERR_INJ_EN enables LFSR-driven injected errors (default: out-of-range errors only).
module cap_mem_resp_model #(
    parameter int          DW        = 33,
    parameter int          AW        = 14,
    parameter int          NOUT      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [3:0]    gnt_wmax,
    input  logic [3:0]    resp_wmax,
    input  logic [2:0]    err_rate,
    input  logic          err_en,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [3:0]    data_be,
    input  logic [31:0]   data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_gnt,
    output logic          data_rvalid,
    output logic [DW-1:0] data_rdata,
    output logic          data_err,
    output logic [4:0]    outst_cnt
);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam int          PW   = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam int          EW   = DW + 1;

    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    gnt_cnt_q, gnt_cnt_d;
    logic [3:0]    rsp_cnt_q, rsp_cnt_d;
    logic          req_q, req_d;
    logic          gnt_q, gnt_d;
    logic          head_new_q, head_new_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;

    logic [EW-1:0] fifo_q [NOUT];
    logic [DW-1:0] ram_q [2**AW];

    logic [AW-1:0] waddr;
    logic [3:0]    gnt_eff, rsp_eff;
    logic          in_range, inj_err, txn_err;
    logic          push, pop, ram_we;
    logic [DW-1:0] ram_rd, ram_wr;
    logic [EW-1:0] push_dat;
    logic          unused_ok;

`ifdef CAP_MEM_ERR_INJ_EN
    assign inj_err   = err_en && (err_rate != 3'd0) && ((lfsr_q[7:0] & (8'hFF >> err_rate)) == 8'd0);
    assign unused_ok = ^data_addr[1:0];
`else
    assign inj_err   = 1'b0;
    assign unused_ok = ^{data_addr[1:0], err_en, err_rate};
`endif

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        req_d  = data_req;

        // A fresh request (rising, or immediately after a grant) takes a newly drawn wait.
        gnt_eff = (data_req && (!req_q || gnt_q))
                ? 4'(lfsr_q[7:0] % ({4'd0, gnt_wmax} + 8'd1))
                : gnt_cnt_q;
        data_gnt  = !rst_i && data_req && (gnt_eff == 4'd0) && (cnt_q < 5'(NOUT));
        gnt_d     = data_gnt;
        gnt_cnt_d = (gnt_eff != 4'd0) ? gnt_eff - 4'd1 : 4'd0;

        rsp_eff   = head_new_q ? 4'(lfsr_q[11:4] % ({4'd0, resp_wmax} + 8'd1)) : rsp_cnt_q;
        pop       = !rst_i && (cnt_q != 5'd0) && (rsp_eff == 4'd0);
        rsp_cnt_d = (rsp_eff != 4'd0) ? rsp_eff - 4'd1 : 4'd0;

        in_range = (data_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
        txn_err  = !in_range || inj_err;
        waddr    = data_addr[AW+1:2];
        ram_rd   = ram_q[waddr];

        ram_wr = ram_rd;
        for (int i = 0; i < 4; i++) begin
            if (data_be[i]) ram_wr[8*i +: 8] = data_wdata[8*i +: 8];
        end
        // A partial-word write can forge part of a capability, so it clears the tag.
        if (data_be == 4'hF) ram_wr[DW-1] = data_wdata[DW-1];
        else if (data_be != 4'h0) ram_wr[DW-1] = 1'b0;

        push     = data_gnt;
        ram_we   = data_gnt && data_we && !txn_err;
        push_dat = {txn_err, (txn_err || data_we) ? {DW{1'b0}} : ram_rd};

        cnt_d  = cnt_q + 5'(push) - 5'(pop);
        wptr_d = push ? ((wptr_q == PW'(NOUT-1)) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop  ? ((rptr_q == PW'(NOUT-1)) ? '0 : rptr_q + 1'b1) : rptr_q;
        head_new_d = (pop && (cnt_d != 5'd0)) || ((cnt_q == 5'd0) && push);

        data_rvalid = pop;
        {data_err, data_rdata} = pop ? fifo_q[rptr_q] : {EW{1'b0}};
        outst_cnt = cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q     <= SEED;
            gnt_cnt_q  <= 4'd0;
            rsp_cnt_q  <= 4'd0;
            req_q      <= 1'b0;
            gnt_q      <= 1'b0;
            head_new_q <= 1'b0;
            cnt_q      <= 5'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            gnt_cnt_q  <= gnt_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            req_q      <= req_d;
            gnt_q      <= gnt_d;
            head_new_q <= head_new_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage arrays carry no reset: memory contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (push)   fifo_q[wptr_q] <= push_dat;
        if (ram_we) ram_q[waddr]   <= ram_wr;
    end
endmodule

// File: tb/tb_cap_mem_resp_model.sv
// Self-checking bench for cap_mem_resp_model: directed scenarios plus randomized traffic vs. a queue/array model.
module tb_cap_mem_resp_model;
    localparam int          NOUT = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  gnt_wmax, resp_wmax;
    logic [2:0]  err_rate;
    logic        err_en;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [32:0] data_wdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [32:0] data_rdata;
    logic [4:0]  outst_cnt;

    cap_mem_resp_model dut (
        .clk_i(clk), .rst_i(rst), .gnt_wmax(gnt_wmax), .resp_wmax(resp_wmax),
        .err_rate(err_rate), .err_en(err_en), .data_req(data_req), .data_we(data_we),
        .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .data_err(data_err), .outst_cnt(outst_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: 16-word memory window, expected-response queue, spec LFSR for error injection.
    logic [32:0] mem_m [16];
    logic [33:0] exp_q [$];
    logic [15:0] lfsr_m = SEED;
    int          n_cmp = 0, n_bad = 0;
    int          head_wait = 0, req_wait = 0, txn_cycles = 0, n_err_rsp = 0;
    logic        last_gnt = 1'b0, rst_seen = 1'b0, last_err = 1'b0;
    logic [32:0] last_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant();
        logic [3:0]  idx;
        logic        inr, inj;
        logic [32:0] w;
        idx = data_addr[5:2];
        inr = (data_addr[31:16] == 16'h8000);
        inj = 1'b0;
`ifdef CAP_MEM_ERR_INJ_EN
        if (err_en && err_rate != 3'd0 && ((lfsr_m[7:0] & (8'hFF >> err_rate)) == 8'h0)) inj = 1'b1;
`endif
        if (!inr || inj) begin
            exp_q.push_back({1'b1, 33'h0});
        end else if (data_we) begin
            w = mem_m[idx];
            for (int b = 0; b < 4; b++) if (data_be[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
            if (data_be == 4'hF) w[32] = data_wdata[32];
            else if (data_be != 4'h0) w[32] = 1'b0;
            mem_m[idx] = w;
            exp_q.push_back({1'b0, 33'h0});
        end else begin
            exp_q.push_back({1'b0, mem_m[idx]});
        end
    endtask

    // One clock: observe at negedge, advance model at posedge, return 1 time unit after the edge.
    task automatic tick();
        int          occ;
        logic [33:0] e;
        @(negedge clk);
        last_gnt = data_gnt;
        if (rst) begin
            check("rst_gnt", data_gnt, 0);
            check("rst_rvalid", data_rvalid, 0);
            check("rst_rsp", {data_err, data_rdata}, 0);
            if (rst_seen) check("rst_outst", outst_cnt, 0);
        end else begin
            occ = exp_q.size();
            check("outst_cnt", outst_cnt, occ);
            if (occ == NOUT) check("gnt_when_full", data_gnt, 0);
            if (data_rvalid) begin
                if (occ == 0) begin
                    check("rvalid_empty", data_rvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", data_err, e[33]);
                    check("rsp_rdata", data_rdata, e[32:0]);
                    last_rdata = data_rdata;
                    last_err   = data_err;
                    if (data_err) n_err_rsp++;
                end
                head_wait = 0;
            end else begin
                check("idle_rsp_zero", {data_err, data_rdata}, 0);
                if (occ != 0) begin
                    head_wait++;
                    check("rsp_wait_bound", head_wait > resp_wmax, 0);
                end
            end
            if (data_gnt) begin
                check("gnt_without_req", data_req, 1);
                model_grant();
                req_wait = 0;
            end else if (data_req && occ < NOUT) begin
                req_wait++;
                check("gnt_wait_bound", req_wait > gnt_wmax, 0);
            end
        end
        @(posedge clk);
        rst_seen = rst;
        if (rst) begin
            exp_q.delete();
            head_wait = 0;
            req_wait  = 0;
            lfsr_m    = SEED;
        end else begin
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
        #1;
    endtask

    task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [32:0] wd);
        data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
        txn_cycles = 0;
        last_gnt   = 1'b0;
        while (!last_gnt && txn_cycles < 200) begin
            tick();
            txn_cycles++;
        end
        if (!last_gnt) check("gnt_timeout", last_gnt, 1);
        data_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        data_req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] off;
        off = {26'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
        if ($urandom_range(7) != 0) return 32'h8000_0000 + off;
        case ($urandom_range(2))
            0:       return 32'h9000_0000 + off;
            1:       return 32'h8001_0000 + off;
            default: return 32'h7FFF_FFC0 + off;
        endcase
    endfunction

    initial begin
        rst = 1'b1; gnt_wmax = 4'd0; resp_wmax = 4'd0; err_rate = 3'd0; err_en = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = '0; data_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            txn(1'b1, 4'hF, 32'h8000_0000 + 32'(i * 4), {1'($urandom), 32'($urandom)});
        drain();

        // Zero-wait write then read of a tagged word.
        txn(1'b1, 4'hF, 32'h8000_0010, 33'h1_DEADBEEF);
        check("zero_wait_gnt_cycles", txn_cycles, 1);
        txn(1'b0, 4'h0, 32'h8000_0010, '0);
        check("zero_wait_gnt_cycles_rd", txn_cycles, 1);
        drain();
        check("tagged_readback", last_rdata, 33'h1_DEADBEEF);

        txn(1'b1, 4'b0001, 32'h8000_0010, 33'h0_0000_0055);
        txn(1'b0, 4'h0, 32'h8000_0010, '0);
        drain();
        check("partial_write_tag_clear", last_rdata, 33'h0_DEADBE55);

        txn(1'b0, 4'h0, 32'h9000_0000, '0);
        drain();
        check("oor_err", last_err, 1);
        check("oor_rdata", last_rdata, 0);
        txn(1'b1, 4'hF, 32'h9000_0010, 33'h1_1234_5678);
        txn(1'b0, 4'h0, 32'h8000_0010, '0);
        drain();
        check("oor_write_ignored", last_rdata, 33'h0_DEADBE55);

        resp_wmax = 4'd15;
        for (int i = 0; i < 6; i++) txn(1'b0, 4'h0, 32'h8000_0000 + 32'(i * 4), '0);
        drain();

        gnt_wmax = 4'd0; resp_wmax = 4'd0; err_rate = 3'd7; err_en = 1'b1;
        n_err_rsp = 0;
        for (int i = 0; i < 256; i++)
            txn(1'b1, 4'hF, 32'h8000_0000 + 32'($urandom_range(15) * 4), {1'($urandom), 32'($urandom)});
        drain();
`ifdef CAP_MEM_ERR_INJ_EN
        check("inj_rate_window", (n_err_rsp >= 64) && (n_err_rsp <= 192), 1);
`else
        check("inj_disabled", n_err_rsp, 0);
`endif
        err_en = 1'b0;
        for (int i = 0; i < 16; i++) txn(1'b0, 4'h0, 32'h8000_0000 + 32'(i * 4), '0);
        drain();

        for (int blk = 0; blk < 6; blk++) begin
            gnt_wmax  = 4'($urandom_range(15));
            resp_wmax = 4'($urandom_range(15));
            err_en    = 1'($urandom);
            err_rate  = 3'($urandom);
            for (int i = 0; i < 40; i++) begin
                txn(1'($urandom), 4'($urandom), rnd_addr(), {1'($urandom), 32'($urandom)});
                if ($urandom_range(3) == 0) tick();
            end
            drain();
        end

        // Reset with responses in flight: nothing may come back afterwards, memory survives.
        gnt_wmax = 4'd0; resp_wmax = 4'd15; err_en = 1'b0;
        for (int i = 0; i < 3; i++) txn(1'b0, 4'h0, 32'h8000_0000 + 32'(i * 4), '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        txn(1'b0, 4'h0, 32'h8000_0010, '0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
